// File: rtl/bus_ctrl_pkg.sv
// Shared types and default parameter values for the 65C02 bus wait-state controller.
package bus_ctrl_pkg;

  typedef enum logic [1:0] {
    REGION_RAM = 2'd0,
    REGION_ROM = 2'd1,
    REGION_IO  = 2'd2
  } region_t;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT    = 2'd1,
    STRETCH = 2'd2,
    DONE    = 2'd3
  } bus_state_t;

  localparam logic [15:0] DEF_ROM_BASE = 16'hC000;
  localparam logic [7:0]  DEF_IO_PAGE  = 8'hBF;
  localparam int unsigned DEF_RAM_WAIT = 0;
  localparam int unsigned DEF_ROM_WAIT = 2;
  localparam int unsigned DEF_IO_WAIT  = 3;
  localparam int unsigned DEF_TIMEOUT  = 255;

endpackage

// File: rtl/bus_addr_decode.sv
// Combinational address decode: maps cpu_a/cpu_vpb to a region and its wait-state count.
module bus_addr_decode
  import bus_ctrl_pkg::*;
#(
  parameter logic [15:0] ROM_BASE = DEF_ROM_BASE,
  parameter logic [7:0]  IO_PAGE  = DEF_IO_PAGE,
  parameter int unsigned RAM_WAIT = DEF_RAM_WAIT,
  parameter int unsigned ROM_WAIT = DEF_ROM_WAIT,
  parameter int unsigned IO_WAIT  = DEF_IO_WAIT
) (
  input  logic [15:0] cpu_a_i,
  input  logic        cpu_vpb_i,
  output region_t     region_o,
  output logic [3:0]  wait_o
);

  // Vector pulls always hit ROM, ahead of the I/O page match.
  always_comb begin
    region_o = REGION_RAM;
    if (!cpu_vpb_i) begin
      region_o = REGION_ROM;
    end else if (cpu_a_i[15:8] == IO_PAGE) begin
      region_o = REGION_IO;
    end else if (cpu_a_i >= ROM_BASE) begin
      region_o = REGION_ROM;
    end else begin
      region_o = REGION_RAM;
    end
  end

  always_comb begin
    wait_o = 4'd0;
    case (region_o)
      REGION_RAM: wait_o = 4'(RAM_WAIT);
      REGION_ROM: wait_o = 4'(ROM_WAIT);
      REGION_IO:  wait_o = 4'(IO_WAIT);
      default:    wait_o = 4'd0;
    endcase
  end

endmodule

// File: rtl/bus_wait_controller.sv
// Bus cycle FSM: chip selects, strobes and rdy wait-state insertion for the 65C02 core.
// Optional I/O stretch timeout with bus_err is enabled by defining BUS_TIMEOUT_EN.
module bus_wait_controller
  import bus_ctrl_pkg::*;
#(
  parameter logic [15:0] ROM_BASE = DEF_ROM_BASE,
  parameter logic [7:0]  IO_PAGE  = DEF_IO_PAGE,
  parameter int unsigned RAM_WAIT = DEF_RAM_WAIT,
  parameter int unsigned ROM_WAIT = DEF_ROM_WAIT,
  parameter int unsigned IO_WAIT  = DEF_IO_WAIT,
  parameter int unsigned TIMEOUT  = DEF_TIMEOUT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        bus_req,
  input  logic [15:0] cpu_a,
  input  logic        cpu_rwb,
  input  logic        cpu_vpb,
  input  logic        io_ready,
  output logic        rdy,
  output logic        ram_cs,
  output logic        rom_cs,
  output logic        io_cs,
  output logic        oe,
  output logic        we,
  output logic        bus_err
);

  bus_state_t state_q, state_d;
  region_t    region_q, region_d, dec_region_s;
  logic       rwb_q, rwb_d;
  logic [3:0] wcnt_q, wcnt_d, dec_wait_s;
  logic       timeout_s;
  logic       rdy_q, ram_cs_q, rom_cs_q, io_cs_q, oe_q, we_q;

  bus_addr_decode #(
    .ROM_BASE (ROM_BASE),
    .IO_PAGE  (IO_PAGE),
    .RAM_WAIT (RAM_WAIT),
    .ROM_WAIT (ROM_WAIT),
    .IO_WAIT  (IO_WAIT)
  ) u_decode (
    .cpu_a_i   (cpu_a),
    .cpu_vpb_i (cpu_vpb),
    .region_o  (dec_region_s),
    .wait_o    (dec_wait_s)
  );

`ifdef BUS_TIMEOUT_EN
  logic [7:0] scnt_q, scnt_d;
  logic       bus_err_q;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      region_q <= REGION_RAM;
      rwb_q    <= 1'b1;
      wcnt_q   <= 4'd0;
    end else begin
      state_q  <= state_d;
      region_q <= region_d;
      rwb_q    <= rwb_d;
      wcnt_q   <= wcnt_d;
    end
  end

  // DONE accepts a new request exactly like IDLE so cycles can run back to back.
  always_comb begin
    state_d   = state_q;
    region_d  = region_q;
    rwb_d     = rwb_q;
    wcnt_d    = wcnt_q;
    timeout_s = 1'b0;
    case (state_q)
      IDLE, DONE: begin
        if (bus_req) begin
          region_d = dec_region_s;
          rwb_d    = cpu_rwb;
          wcnt_d   = (dec_wait_s != 4'd0) ? dec_wait_s - 4'd1 : 4'd0;
          if (dec_wait_s != 4'd0) begin
            state_d = WAIT;
          end else if (dec_region_s == REGION_IO && !io_ready) begin
            state_d = STRETCH;
          end else begin
            state_d = DONE;
          end
        end else begin
          state_d = IDLE;
        end
      end
      WAIT: begin
        if (wcnt_q != 4'd0) begin
          wcnt_d = wcnt_q - 4'd1;
        end else if (region_q == REGION_IO && !io_ready) begin
          state_d = STRETCH;
        end else begin
          state_d = DONE;
        end
      end
      STRETCH: begin
        if (io_ready) begin
          state_d = DONE;
        end else begin
`ifdef BUS_TIMEOUT_EN
          if (scnt_q == 8'(TIMEOUT - 1)) begin
            state_d   = DONE;
            timeout_s = 1'b1;
          end else begin
            state_d = STRETCH;
          end
`else
          state_d = STRETCH;
`endif
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs are computed from the next state so the registered copy lines up with the state.
  always_ff @(posedge clk) begin
    if (reset) begin
      rdy_q    <= 1'b1;
      ram_cs_q <= 1'b0;
      rom_cs_q <= 1'b0;
      io_cs_q  <= 1'b0;
      oe_q     <= 1'b0;
      we_q     <= 1'b0;
    end else begin
      rdy_q    <= !(state_d == WAIT || state_d == STRETCH);
      ram_cs_q <= (state_d != IDLE) && (region_d == REGION_RAM);
      rom_cs_q <= (state_d != IDLE) && (region_d == REGION_ROM);
      io_cs_q  <= (state_d != IDLE) && (region_d == REGION_IO);
      oe_q     <= (state_d != IDLE) && rwb_d;
      we_q     <= (state_d == DONE) && !rwb_d && !timeout_s;
    end
  end

`ifdef BUS_TIMEOUT_EN
  // Stretch counter restarts on every entry into STRETCH.
  always_comb begin
    scnt_d = scnt_q;
    if (state_d == STRETCH && state_q != STRETCH) begin
      scnt_d = 8'd0;
    end else if (state_q == STRETCH) begin
      scnt_d = scnt_q + 8'd1;
    end else begin
      scnt_d = scnt_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      scnt_q    <= 8'd0;
      bus_err_q <= 1'b0;
    end else begin
      scnt_q    <= scnt_d;
      bus_err_q <= timeout_s;
    end
  end

  assign bus_err = bus_err_q;
`else
  assign bus_err = 1'b0;
`endif

  assign rdy    = rdy_q;
  assign ram_cs = ram_cs_q;
  assign rom_cs = rom_cs_q;
  assign io_cs  = io_cs_q;
  assign oe     = oe_q;
  assign we     = we_q;

endmodule
